alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width of operands and results.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1 / in_ready  out  1  upstream (decode) handshake.
REQ-005 rs1_addr, rs2_addr  in  5 each  source register indices.
REQ-006 rs1_data, rs2_data, imm, pc  in  XLEN each  register-file read data, immediate, instruction PC.
REQ-007 src_a_sel  in  2 (00 rs1, 01 pc, 10 zero, 11 reserved -> zero) / src_b_sel  in  2 (00 rs2, 01 imm, 10 constant 4, 11 reserved -> zero).
REQ-008 alu_ctrl_in  in  4 / rd_in  in  5 / reg_write_in  in  1  decoded ALU op, destination, write enable.
REQ-009 flush  in  1  kill held instruction.
REQ-010 exm_rd  in  5 / exm_reg_write  in  1 / exm_result  in  XLEN  forwarding source, EX/MEM.
REQ-011 mwb_rd  in  5 / mwb_reg_write  in  1 / mwb_result  in  XLEN  forwarding source, MEM/WB.
REQ-012 out_valid  out  1 / out_ready  in  1  downstream (ALU stage) handshake.
REQ-013 a, b  out  XLEN / ALUControl  out  4 / rd_out  out  5 / reg_write_out  out  1 / store_data  out  XLEN  registered operands and control.

Function
REQ-014 Block SHALL be a single-entry registered stage: latency exactly 1 cycle from accepted input to out_valid.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinational.
REQ-016 Transfer in SHALL occur when in_valid && in_ready; all output registers load together on that edge.
REQ-017 When out_valid && out_ready and no transfer in, out_valid SHALL clear next cycle; simultaneous drain and load SHALL keep out_valid high with new data (no bubble).
REQ-018 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-019 flush SHALL clear out_valid and reg_write_out next cycle, overriding any simultaneous load; data registers may hold.
REQ-020 Forwarded rsN value: exm_result if exm_reg_write && exm_rd==rsN_addr && exm_rd!=0; else mwb_result if mwb_reg_write && mwb_rd==rsN_addr && mwb_rd!=0; else rsN_data. EX/MEM SHALL win when both match.
REQ-021 Index 0 SHALL never be forwarded; rsN_data passes through.
REQ-022 a, b SHALL be selected per REQ-007 using forwarded rs1/rs2; store_data SHALL be forwarded rs2 regardless of src_b_sel.
REQ-023 ALUControl SHALL pass alu_ctrl_in unmodified; no validation of encoding.
REQ-024 All arithmetic is selection only; constant 4 is zero-extended to XLEN.

Reset
REQ-025 On rst_n low, immediately: out_valid=0, reg_write_out=0, a=b=store_data=0, ALUControl=4'b0000 (ADD), rd_out=0.
REQ-026 Reset mid-transfer SHALL discard the held instruction; first post-reset cycle SHALL present in_ready=1.

Configuration
REQ-027 Macro FORWARDING_EN: defined -> REQ-020 forwarding active; undefined -> rsN_data used directly, exm_*/mwb_* inputs ignored, ports retained.

Structure
REQ-028 Shared package alu_pkg SHALL hold ALUControl encodings (ADD 0000 .. JALR 1101), src_a/src_b select encodings, XLEN default.
REQ-029 One sub-module forward_unit SHALL implement REQ-020/021 for one operand; instantiated twice.

Verification
REQ-030 Reset: rst_n=0 mid-transfer -> out_valid=0, ALUControl=0000, in_ready=1 after release.
REQ-031 Basic: rs1_data=5, imm=7, src_a_sel=00, src_b_sel=01, alu_ctrl_in=0000 -> next cycle a=5, b=7, ALUControl=0000, out_valid=1.
REQ-032 Forward priority: rs1_addr=3, exm_rd=3 result 0xAA, mwb_rd=3 result 0xBB, rs1_data=0x11 -> a=0xAA; exm_reg_write=0 -> a=0xBB; with FORWARDING_EN undefined -> a=0x11.
REQ-033 x0: rs2_addr=0, exm_rd=0, exm_reg_write=1, rs2_data=0 -> b=0, store_data=0.
REQ-034 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; out_ready=1 with new input -> next instruction loaded, out_valid stays 1.
REQ-035 Flush: flush=1 coincident with in_valid=1, in_ready=1 -> next cycle out_valid=0, reg_write_out=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control encodings, operand-select encodings and datapath width
package alu_pkg;
    localparam int XLEN = 32;
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_LUI   = 4'b1010,
        ALU_AUIPC = 4'b1011,
        ALU_JAL   = 4'b1100,
        ALU_JALR  = 4'b1101
    } alu_op_e;
    typedef enum logic [1:0] {
        SRC_A_RS1  = 2'b00,
        SRC_A_PC   = 2'b01,
        SRC_A_ZERO = 2'b10
    } src_a_e;
    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } src_b_e;
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode-side and ALU-side handshake/bus of the operand stage
// master: upstream/downstream environment; slave: the operand stage itself
interface alu_operand_stage_if #(parameter int XLEN = alu_pkg::XLEN);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [1:0]      src_a_sel;
    logic [1:0]      src_b_sel;
    logic [3:0]      alu_ctrl_in;
    logic [4:0]      rd_in;
    logic            reg_write_in;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      ALUControl;
    logic [4:0]      rd_out;
    logic            reg_write_out;
    logic [XLEN-1:0] store_data;
    modport master (
        output in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, pc,
               src_a_sel, src_b_sel, alu_ctrl_in, rd_in, reg_write_in, out_ready,
        input  in_ready, out_valid, a, b, ALUControl, rd_out, reg_write_out, store_data
    );
    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, pc,
               src_a_sel, src_b_sel, alu_ctrl_in, rd_in, reg_write_in, out_ready,
        output in_ready, out_valid, a, b, ALUControl, rd_out, reg_write_out, store_data
    );
endinterface

// File: rtl/alu_operand_stage_forward_unit.sv
// forward_unit: bypass selection for one source operand
// in: rs_addr/rs_data, EX/MEM and MEM/WB rd/reg_write/result; out: fwd
// FORWARDING_EN defined -> bypass active; undefined -> rs_data passes through
module forward_unit #(parameter int XLEN = alu_pkg::XLEN) (
    input  logic [4:0]      rs_addr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [4:0]      exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [4:0]      mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] fwd
);
`ifdef FORWARDING_EN
    logic exm_hit, mwb_hit;
    // x0 is hardwired, so a match on index 0 is never a real producer
    assign exm_hit = exm_reg_write && exm_rd == rs_addr && exm_rd != 5'd0;
    assign mwb_hit = mwb_reg_write && mwb_rd == rs_addr && mwb_rd != 5'd0;
    assign fwd = exm_hit ? exm_result : mwb_hit ? mwb_result : rs_data;
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs_addr, exm_rd, exm_reg_write, exm_result, mwb_rd, mwb_reg_write, mwb_result};
    assign fwd = rs_data;
`endif
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: single-entry registered operand select/forward stage
// ports: clk, rst_n (async active-low), bus (alu_operand_stage_if.slave: decode and ALU handshakes),
//        flush, exm_rd/exm_reg_write/exm_result, mwb_rd/mwb_reg_write/mwb_result
// macro: FORWARDING_EN enables EX/MEM and MEM/WB bypass
module alu_operand_stage
    import alu_pkg::*;
#(parameter int XLEN = alu_pkg::XLEN) (
    input  logic                clk,
    input  logic                rst_n,
    alu_operand_stage_if.slave  bus,
    input  logic                flush,
    input  logic [4:0]          exm_rd,
    input  logic                exm_reg_write,
    input  logic [XLEN-1:0]     exm_result,
    input  logic [4:0]          mwb_rd,
    input  logic                mwb_reg_write,
    input  logic [XLEN-1:0]     mwb_result
);
    logic [XLEN-1:0] rs1_fwd, rs2_fwd, a_nxt, b_nxt;
    logic            load;
    forward_unit #(.XLEN(XLEN)) u_fwd1 (
        .rs_addr(bus.rs1_addr), .rs_data(bus.rs1_data),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .fwd(rs1_fwd)
    );
    forward_unit #(.XLEN(XLEN)) u_fwd2 (
        .rs_addr(bus.rs2_addr), .rs_data(bus.rs2_data),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .fwd(rs2_fwd)
    );
    always_comb begin
        a_nxt = bus.src_a_sel == SRC_A_RS1 ? rs1_fwd :
                bus.src_a_sel == SRC_A_PC  ? bus.pc  : '0;
        b_nxt = bus.src_b_sel == SRC_B_RS2  ? rs2_fwd :
                bus.src_b_sel == SRC_B_IMM  ? bus.imm :
                bus.src_b_sel == SRC_B_FOUR ? XLEN'(4) : '0;
    end
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign load = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid     <= 1'b0;
            bus.reg_write_out <= 1'b0;
            bus.a             <= '0;
            bus.b             <= '0;
            bus.store_data    <= '0;
            bus.ALUControl    <= ALU_ADD;
            bus.rd_out        <= '0;
        end else begin
            if (flush) begin
                bus.out_valid     <= 1'b0;
                bus.reg_write_out <= 1'b0;
            end else if (load) begin
                bus.out_valid     <= 1'b1;
                bus.reg_write_out <= bus.reg_write_in;
            end else if (bus.out_ready) begin
                bus.out_valid     <= 1'b0;
            end
            if (load && !flush) begin
                bus.a          <= a_nxt;
                bus.b          <= b_nxt;
                bus.store_data <= rs2_fwd;
                bus.ALUControl <= bus.alu_ctrl_in;
                bus.rd_out     <= bus.rd_in;
            end
        end
    end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed self-checking bench for alu_operand_stage
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  exm_rd = '0, mwb_rd = '0;
    logic        exm_reg_write = 1'b0, mwb_reg_write = 1'b0;
    logic [31:0] exm_result = '0, mwb_result = '0;
    int          checks = 0;
    int          errors = 0;
    alu_operand_stage_if #(.XLEN(32)) bus ();
    alu_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] ctrl,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] p, input logic [4:0] rd);
        bus.src_a_sel = sa;
        bus.src_b_sel = sb;
        bus.alu_ctrl_in = ctrl;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        bus.imm = im;
        bus.pc = p;
        bus.rd_in = rd;
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        bus.reg_write_in = 1'b0;
        drive(2'b00, 2'b00, 4'b0000, '0, '0, '0, '0, '0);
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_alu_ctrl", 32'(bus.ALUControl), 0);
        chk("rst_a", bus.a, 0);
        step();
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        // basic: a=rs1, b=imm
        bus.in_valid = 1'b1;
        bus.reg_write_in = 1'b1;
        bus.rs1_addr = 5'd1;
        bus.rs2_addr = 5'd2;
        drive(2'b00, 2'b01, 4'b0000, 32'd5, 32'h99, 32'd7, 32'h400, 5'd9);
        step();
        chk("basic_a", bus.a, 5);
        chk("basic_b", bus.b, 7);
        chk("basic_ctrl", 32'(bus.ALUControl), 0);
        chk("basic_valid", 32'(bus.out_valid), 1);
        chk("basic_rd", 32'(bus.rd_out), 9);
        chk("basic_rw", 32'(bus.reg_write_out), 1);
        chk("basic_store", bus.store_data, 32'h99);
        // pc and constant 4 with JALR control
        drive(2'b01, 2'b10, 4'b1101, 32'd5, 32'h55, 32'd7, 32'h400, 5'd1);
        step();
        chk("pc_a", bus.a, 32'h400);
        chk("four_b", bus.b, 4);
        chk("jalr_ctrl", 32'(bus.ALUControl), 32'hd);
        chk("pc_valid", 32'(bus.out_valid), 1);
        // reserved selects give zero, store_data still rs2
        drive(2'b11, 2'b11, 4'b0111, 32'd5, 32'h66, 32'd7, 32'h400, 5'd1);
        step();
        chk("rsv_a", bus.a, 0);
        chk("rsv_b", bus.b, 0);
        chk("rsv_store", bus.store_data, 32'h66);
        // zero select / rs2 select
        drive(2'b10, 2'b00, 4'b0001, 32'd5, 32'h77, 32'd7, 32'h400, 5'd1);
        step();
        chk("zero_a", bus.a, 0);
        chk("rs2_b", bus.b, 32'h77);
        // forwarding priority
        bus.rs1_addr = 5'd3;
        exm_rd = 5'd3; exm_reg_write = 1'b1; exm_result = 32'hAA;
        mwb_rd = 5'd3; mwb_reg_write = 1'b1; mwb_result = 32'hBB;
        drive(2'b00, 2'b01, 4'b0000, 32'h11, 32'h0, 32'd0, 32'h0, 5'd1);
        step();
`ifdef FORWARDING_EN
        chk("fwd_exm_a", bus.a, 32'hAA);
`else
        chk("fwd_exm_a", bus.a, 32'h11);
`endif
        exm_reg_write = 1'b0;
        step();
`ifdef FORWARDING_EN
        chk("fwd_mwb_a", bus.a, 32'hBB);
`else
        chk("fwd_mwb_a", bus.a, 32'h11);
`endif
        // x0 never forwarded
        bus.rs2_addr = 5'd0;
        exm_rd = 5'd0; exm_reg_write = 1'b1; exm_result = 32'hDEAD;
        mwb_rd = 5'd0; mwb_reg_write = 1'b1; mwb_result = 32'hBEEF;
        drive(2'b00, 2'b00, 4'b0000, 32'h11, 32'h0, 32'd0, 32'h0, 5'd1);
        step();
        chk("x0_b", bus.b, 0);
        chk("x0_store", bus.store_data, 0);
        exm_reg_write = 1'b0;
        mwb_reg_write = 1'b0;
        // backpressure
        drive(2'b00, 2'b01, 4'b0010, 32'h21, 32'h0, 32'h1, 32'h0, 5'd4);
        step();
        chk("bp_first_a", bus.a, 32'h21);
        bus.out_ready = 1'b0;
        drive(2'b00, 2'b01, 4'b0011, 32'h22, 32'h0, 32'h2, 32'h0, 5'd6);
        #1;
        chk("bp_in_ready", 32'(bus.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_a", bus.a, 32'h21);
            chk("bp_hold_ctrl", 32'(bus.ALUControl), 32'h2);
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
            chk("bp_hold_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 1);
        step();
        chk("bp_next_a", bus.a, 32'h22);
        chk("bp_next_rd", 32'(bus.rd_out), 6);
        chk("bp_next_valid", 32'(bus.out_valid), 1);
        // drain without load
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", 32'(bus.out_valid), 0);
        // flush over a coincident load while holding a valid entry
        bus.in_valid = 1'b1;
        step();
        chk("pre_flush_valid", 32'(bus.out_valid), 1);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 1);
        step();
        chk("flush_valid", 32'(bus.out_valid), 0);
        chk("flush_rw", 32'(bus.reg_write_out), 0);
        flush = 1'b0;
        // reset mid-transfer with a held entry
        drive(2'b00, 2'b01, 4'b1000, 32'h31, 32'h0, 32'h3, 32'h0, 5'd7);
        step();
        bus.out_ready = 1'b0;
        chk("mid_valid", 32'(bus.out_valid), 1);
        chk("mid_ctrl", 32'(bus.ALUControl), 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 0);
        chk("async_rst_ctrl", 32'(bus.ALUControl), 0);
        chk("async_rst_rw", 32'(bus.reg_write_out), 0);
        chk("async_rst_rd", 32'(bus.rd_out), 0);
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(bus.in_ready), 1);
        chk("post_rst_valid", 32'(bus.out_valid), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
